// File: rtl/lms_update_ctrl_pkg.sv
// Shared types and default sizes for the LMS iteration controller.
package lms_ctrl_pkg;

  localparam int LMS_NTAPS  = 16;
  localparam int LMS_TAP_W  = 4;
  localparam int LMS_ITER_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    MAC,
    SETTLE,
    ERR,
    UPD,
    OUT
  } lms_state_e;

endpackage

// File: rtl/lms_update_ctrl_if.sv
// Sample-in / result-out handshake between the LMS controller and its neighbours.
interface lms_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/lms_update_ctrl_iter_cnt.sv
// Saturating training-iteration counter with clear priority and limit compare.
module lms_iter_cnt
  import lms_ctrl_pkg::*;
#(
  parameter int ITER_W = LMS_ITER_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              inc,
  input  logic [ITER_W-1:0] limit,
  output logic [ITER_W-1:0] cnt,
  output logic              frozen
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      frozen <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      frozen <= 1'b0;
    end else begin
      if (inc && (cnt != {ITER_W{1'b1}})) begin
        cnt <= cnt + ITER_W'(1);
      end
      // Compares the already-registered count, so frozen trails cnt by one cycle.
      frozen <= (limit != '0) && (cnt >= limit);
    end
  end

endmodule

// File: rtl/lms_update_ctrl.sv
// LMS iteration sequencer: sample handshake, tap MAC stepping, error latch, weight update.
// Optional LMS_CTRL_SETTLE_EN inserts a one-cycle pipeline drain state before ERR.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for a sample
// SHIFT  | shift delay line, clear accumulator
// MAC    | accumulate tap tap_sel, NTAPS cycles
// SETTLE | multiplier/accumulator drain (LMS_CTRL_SETTLE_EN only)
// ERR    | latch error, decide on update
// UPD    | weight_cal_state pulse, count the update
// OUT    | out_valid held until out_ready
module lms_update_ctrl
  import lms_ctrl_pkg::*;
#(
  parameter int NTAPS  = LMS_NTAPS,
  parameter int TAP_W  = LMS_TAP_W,
  parameter int ITER_W = LMS_ITER_W
) (
  input  logic              clk,
  input  logic              rstn,
  lms_ctrl_if.slave         hs,
  input  logic              train_en,
  input  logic [ITER_W-1:0] iter_limit,
  input  logic              iter_clr,
  output logic              shift_en,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [TAP_W-1:0]  tap_sel,
  output logic              err_latch,
  output logic              weight_cal_state,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              frozen
);

  lms_state_e state;
  logic       in_ready_q;
  logic       out_valid_q;

  assign hs.in_ready  = in_ready_q;
  assign hs.out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      in_ready_q       <= 1'b1;
      out_valid_q      <= 1'b0;
      shift_en         <= 1'b0;
      acc_clr          <= 1'b0;
      acc_en           <= 1'b0;
      tap_sel          <= '0;
      err_latch        <= 1'b0;
      weight_cal_state <= 1'b0;
    end else begin
      shift_en         <= 1'b0;
      acc_clr          <= 1'b0;
      acc_en           <= 1'b0;
      err_latch        <= 1'b0;
      weight_cal_state <= 1'b0;
      case (state)
        IDLE: begin
          if (hs.in_valid) begin
            state      <= SHIFT;
            in_ready_q <= 1'b0;
            shift_en   <= 1'b1;
            acc_clr    <= 1'b1;
          end
        end
        SHIFT: begin
          state   <= MAC;
          acc_en  <= 1'b1;
          tap_sel <= '0;
        end
        MAC: begin
          if (tap_sel == TAP_W'(NTAPS - 1)) begin
            tap_sel <= '0;
`ifdef LMS_CTRL_SETTLE_EN
            state <= SETTLE;
`else
            state     <= ERR;
            err_latch <= 1'b1;
`endif
          end else begin
            tap_sel <= tap_sel + TAP_W'(1);
            acc_en  <= 1'b1;
          end
        end
        SETTLE: begin
          state     <= ERR;
          err_latch <= 1'b1;
        end
        ERR: begin
          if (train_en && !frozen) begin
            state            <= UPD;
            weight_cal_state <= 1'b1;
          end else begin
            state       <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        UPD: begin
          state       <= OUT;
          out_valid_q <= 1'b1;
        end
        OUT: begin
          if (hs.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          tap_sel     <= '0;
        end
      endcase
    end
  end

  // The registered update strobe is the increment, so the count lands as UPD exits.
  lms_iter_cnt #(.ITER_W(ITER_W)) u_iter_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (iter_clr),
    .inc    (weight_cal_state),
    .limit  (iter_limit),
    .cnt    (iter_cnt),
    .frozen (frozen)
  );

endmodule

// File: tb/tb_lms_update_ctrl.sv
// Self-checking bench for lms_update_ctrl: vector table, reset abort, randomized iterations.
module tb_lms_update_ctrl;

  localparam int NTAPS = 16;
`ifdef LMS_CTRL_SETTLE_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam logic [10:0] IDLE_V = 11'h400;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        train_en = 1'b0;
  logic [15:0] iter_limit = '0;
  logic        iter_clr = 1'b0;
  logic        shift_en, acc_clr, acc_en, err_latch, weight_cal_state, frozen;
  logic [3:0]  tap_sel;
  logic [15:0] iter_cnt;

  int n_checks = 0;
  int n_fail = 0;

  lms_ctrl_if hs ();

  lms_update_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .hs               (hs),
    .train_en         (train_en),
    .iter_limit       (iter_limit),
    .iter_clr         (iter_clr),
    .shift_en         (shift_en),
    .acc_clr          (acc_clr),
    .acc_en           (acc_en),
    .tap_sel          (tap_sel),
    .err_latch        (err_latch),
    .weight_cal_state (weight_cal_state),
    .iter_cnt         (iter_cnt),
    .frozen           (frozen)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          te;
    logic [15:0] lim;
    int          hold;
    bit          clr_before;
    bit          clr_upd;
    bit          exp_upd;
    logic [15:0] exp_cnt;
    bit          exp_frz;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [10:0] obs();
    return {hs.in_ready, hs.out_valid, shift_en, acc_clr, acc_en, err_latch,
            weight_cal_state, tap_sel};
  endfunction

  // Expected strobes k cycles after the accepting edge.
  function automatic logic [10:0] expv(int k, bit upd);
    logic [10:0] v;
    int lat;
    v   = '0;
    lat = NTAPS + 2 + S + int'(upd);
    if (k == 0) v[8:7] = 2'b11;
    else if (k >= 1 && k <= NTAPS) begin
      v[6]   = 1'b1;
      v[3:0] = 4'(k - 1);
    end
    else if (k == NTAPS + 1 + S) v[5] = 1'b1;
    else if (upd && k == NTAPS + 2 + S) v[4] = 1'b1;
    if (k >= lat) v[9] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    iter_clr = 1'b1;
    tick();
    iter_clr = 1'b0;
    check("clr_cnt", 32'(iter_cnt), 0);
    check("clr_frozen", 32'(frozen), 0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!hs.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("idle_wait", 32'(hs.in_ready), 1);
  endtask

  task automatic run_iter(input bit te, input logic [15:0] lim, input int hold,
                          input bit clr_upd, input bit exp_upd,
                          input logic [15:0] exp_cnt, input bit exp_frz);
    int lat;
    lat = NTAPS + 2 + S + int'(exp_upd);
    wait_idle();
    train_en     = te;
    iter_limit   = lim;
    hs.out_ready = (hold == 0);
    hs.in_valid  = 1'b1;
    tick();
    hs.in_valid = 1'b0;
    for (int k = 0; k < lat; k++) begin
      check("trace", 32'(obs()), 32'(expv(k, exp_upd)));
      iter_clr = clr_upd && (k == NTAPS + 2 + S);
      if (k >= 1) hs.in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    hs.in_valid = 1'b0;
    iter_clr    = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      check("out_hold", 32'(obs()), 32'(expv(lat, exp_upd)));
      if (h == hold) hs.out_ready = 1'b1;
      tick();
    end
    check("back_idle", 32'(obs()), 32'(IDLE_V));
    check("iter_cnt", 32'(iter_cnt), 32'(exp_cnt));
    check("frozen", 32'(frozen), 32'(exp_frz));
  endtask

  initial begin
    logic [15:0] m_cnt;
    bit          te, upd, clr_upd, frz;
    logic [15:0] lim;
    int          hold;

    //        te lim  hold clrB clrU upd cnt frz
    vecs[0] = '{1, 16'd0, 0, 1, 0, 1, 16'd1, 0};
    vecs[1] = '{0, 16'd0, 0, 0, 0, 0, 16'd1, 0};
    vecs[2] = '{1, 16'd3, 0, 1, 0, 1, 16'd1, 0};
    vecs[3] = '{1, 16'd3, 0, 0, 0, 1, 16'd2, 0};
    vecs[4] = '{1, 16'd3, 0, 0, 0, 1, 16'd3, 1};
    vecs[5] = '{1, 16'd3, 0, 0, 0, 0, 16'd3, 1};
    vecs[6] = '{1, 16'd3, 0, 0, 0, 0, 16'd3, 1};
    vecs[7] = '{1, 16'd3, 0, 1, 0, 1, 16'd1, 0};
    vecs[8] = '{1, 16'd0, 10, 0, 0, 1, 16'd2, 0};
    vecs[9] = '{1, 16'd0, 0, 0, 1, 1, 16'd0, 0};

    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("reset_obs", 32'(obs()), 32'(IDLE_V));
    check("reset_cnt", 32'(iter_cnt), 0);
    check("reset_frozen", 32'(frozen), 0);

    foreach (vecs[i]) begin
      if (vecs[i].clr_before) do_clr();
      run_iter(vecs[i].te, vecs[i].lim, vecs[i].hold, vecs[i].clr_upd,
               vecs[i].exp_upd, vecs[i].exp_cnt, vecs[i].exp_frz);
    end

    // Count one update so the reset abort has something to clear.
    run_iter(1, 16'd0, 0, 0, 1, 16'd1, 0);
    wait_idle();
    train_en    = 1'b1;
    iter_limit  = '0;
    hs.in_valid = 1'b1;
    tick();
    hs.in_valid = 1'b0;
    repeat (8) tick();
    check("abort_tap", 32'(tap_sel), 7);
    #2 rstn = 1'b0;
    #1;
    check("abort_obs", 32'(obs()), 32'(IDLE_V));
    check("abort_cnt", 32'(iter_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (NTAPS + 4) begin
      tick();
      check("abort_no_upd", 32'(obs()), 32'(IDLE_V));
    end
    run_iter(1, 16'd0, 2, 0, 1, 16'd1, 0);

    m_cnt = 16'd1;
    for (int i = 0; i < 40; i++) begin
      te   = ($urandom_range(0, 3) != 0);
      lim  = 16'($urandom_range(0, 6));
      hold = $urandom_range(0, 3);
      clr_upd = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) begin
        do_clr();
        m_cnt = '0;
      end
      upd = te && !((lim != 0) && (m_cnt >= lim));
      if (upd) begin
        if (clr_upd) m_cnt = '0;
        else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      frz = (lim != 0) && (m_cnt >= lim);
      run_iter(te, lim, hold, clr_upd && upd, upd, m_cnt, frz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lms_update_ctrl.md
Name: lms_update_ctrl

Overview:
Sequencer for one LMS adaptive-filter iteration per input sample.
- Handshakes samples in.
- Shifts the reference tap delay line.
- Steps the serial FIR multiply-accumulate over all taps.
- Latches the error.
- Pulses the weight-bank update enable (weight_cal_state), limiting the total number of training iterations.
- Sits between the sample source, the tap/accumulator datapath, and the 16-tap weight register bank.

Parameters:
NTAPS, 16, number of filter taps (>=2)
TAP_W, 4, width of tap_sel; equals clog2(NTAPS)
ITER_W, 16, width of the iteration counter and limit

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous assert, active-low
in_valid  in  1  new sample/desired pair available
in_ready  out  1  controller can accept a sample
out_valid  out  1  filter output y and error e valid
out_ready  in  1  consumer accepts the output
train_en  in  1  weight updates permitted
iter_limit  in  ITER_W  maximum number of updates; 0 = unlimited
iter_clr  in  1  synchronous clear of iter_cnt and frozen
shift_en  out  1  shift the reference delay line by one
acc_clr  out  1  clear the FIR accumulator
acc_en  out  1  accumulate the product for tap_sel
tap_sel  out  TAP_W  tap index for the MAC
err_latch  out  1  capture e = desired - y
weight_cal_state  out  1  one-cycle weight update enable
iter_cnt  out  ITER_W  number of updates performed
frozen  out  1  iteration limit reached

Behaviour:
- Clock, reset, and decode:
  - One clock (clk). Reset is asynchronous and active-low (rstn).
  - All outputs are Moore-decoded from registered state and counters; there are no combinational input-to-output paths.
- Reset values:
  - State IDLE, so in_ready=1.
  - All other outputs are 0, including tap_sel=0, iter_cnt=0, and frozen=0.
- States and transitions:
  - IDLE: in_ready=1. When in_valid=1, go to SHIFT.
  - SHIFT (1 cycle): shift_en=1, acc_clr=1. Go to MAC with tap_sel=0.
  - MAC (NTAPS cycles): acc_en=1. tap_sel increments 0..NTAPS-1. When tap_sel reaches NTAPS-1, go to ERR and reset tap_sel to 0.
  - ERR (1 cycle): err_latch=1. train_en and frozen are sampled here:
    - If train_en=1 and frozen=0, go to UPD.
    - Otherwise, go to OUT.
  - UPD (1 cycle): weight_cal_state=1. iter_cnt increments. Go to OUT.
  - OUT: out_valid=1, held with stable data until out_ready=1, then go to IDLE.
- Throughput: one sample per iteration; in_ready=0 outside IDLE.
- Latency, measured from the accepting edge to out_valid rising:
  - NTAPS+3 cycles with an update.
  - NTAPS+2 cycles without an update.
- Iteration counter:
  - frozen = (iter_limit != 0) && (iter_cnt >= iter_limit).
  - frozen is registered and updated the cycle after iter_cnt or iter_limit changes.
  - iter_cnt saturates at all-ones; there is no wrap-around.
- iter_clr:
  - Zeroes iter_cnt and frozen on the next edge, in any state.
  - If iter_clr coincides with UPD, the clear wins: iter_cnt=0 and weight_cal_state still pulses.
- Changes to train_en or iter_limit outside ERR have no effect on the current iteration.
- Asserting rstn mid-iteration aborts immediately to IDLE; no weight_cal_state pulse is produced.
- out_ready asserted while not in OUT is ignored.

Optional Feature:
LMS_CTRL_SETTLE_EN
- Defined: inserts a SETTLE state (1 cycle, all strobes 0) between MAC and ERR, so that the pipelined multiplier/accumulator can drain. Latency increases by 1 (NTAPS+4 / NTAPS+3).
- Undefined: MAC goes directly to ERR.

Decomposition:
- Package lms_ctrl_pkg holds:
  - state enum (IDLE, SHIFT, MAC, SETTLE, ERR, UPD, OUT)
  - NTAPS, TAP_W, and ITER_W defaults
- Sub-module lms_iter_cnt:
  - Contains the saturating counter, the clear/increment priority, and the frozen compare.
  - The FSM and tap counter stay in the top module.

Test Plan:
- Reset, then one sample (train_en=1, limit=0, out_ready=1):
  - shift_en and acc_clr for 1 cycle.
  - acc_en for 16 cycles with tap_sel 0..15.
  - err_latch, then weight_cal_state.
  - out_valid at the 19th edge after acceptance; iter_cnt=1.
- train_en=0:
  - No weight_cal_state pulse.
  - out_valid at edge 18; iter_cnt unchanged.
- iter_limit=3, 5 back-to-back samples:
  - Exactly 3 weight_cal_state pulses.
  - frozen=1 after the 3rd; iter_cnt=3.
  - iter_clr, then the next sample updates: iter_cnt=1.
- out_ready held 0 for 10 cycles in OUT:
  - out_valid stays high and in_ready stays 0.
  - Release returns to IDLE the next cycle.
- rstn pulsed low during MAC at tap_sel=7:
  - All outputs return to reset values asynchronously, with no update pulse.
  - The next sample completes normally.
- With LMS_CTRL_SETTLE_EN defined:
  - One idle cycle between the last acc_en and err_latch.
  - out_valid at edge 20.
